// File: rtl/km_pkg.sv
// Shared constants and helpers for the pipelined Karatsuba/Barrett modular multiplier.
package km_pkg;

   localparam int unsigned KM_WIDTH_DEF = 14;
   localparam int unsigned KM_Q_DEF     = 16381;
   localparam int unsigned KM_WIDTH_MAX = 32;

   // Sized for the widest legal WIDTH; instances keep the low 2*WIDTH bits.
   typedef logic [2*KM_WIDTH_MAX-1:0] km_prod_t;

   function automatic km_prod_t km_barrett_mu(input int unsigned width, input int unsigned q);
      logic [2*KM_WIDTH_MAX:0] num;
      logic [2*KM_WIDTH_MAX:0] den;
      logic [2*KM_WIDTH_MAX:0] quot;
      num            = '0;
      num[2*width]   = 1'b1;
      den            = '0;
      den[31:0]      = q;
      quot           = num / den;
      return quot[2*KM_WIDTH_MAX-1:0];
   endfunction

endpackage

// File: rtl/km_kara_mul.sv
// Combinational one-level Karatsuba multiplier returning the partials z0, z1, z2.
module km_kara_mul import km_pkg::*; #(
   parameter int unsigned WIDTH = KM_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] z0,
   output logic [WIDTH+1:0] z1,
   output logic [WIDTH-1:0] z2
);

   localparam int unsigned H = WIDTH / 2;

   logic [H:0] sum_a;
   logic [H:0] sum_b;

   always_comb begin
      sum_a = {1'b0, a[WIDTH-1:H]} + {1'b0, a[H-1:0]};
      sum_b = {1'b0, b[WIDTH-1:H]} + {1'b0, b[H-1:0]};
      z2    = {{H{1'b0}}, a[WIDTH-1:H]} * {{H{1'b0}}, b[WIDTH-1:H]};
      z0    = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};
      z1    = {{(H+1){1'b0}}, sum_a} * {{(H+1){1'b0}}, sum_b};
   end

endmodule

// File: rtl/km_modmul_pipe.sv
// Four-stage streaming p = (a*b) mod Q: Karatsuba multiply, then Barrett reduction.
// Define KM_MODMUL_RANGE_CHECK_EN to fold operands in [Q, 2^WIDTH) and flag them on range_err.
module km_modmul_pipe import km_pkg::*; #(
   parameter int unsigned WIDTH = KM_WIDTH_DEF,
   parameter int unsigned Q     = KM_Q_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p,
   output logic             range_err
);

   localparam int unsigned   H       = WIDTH / 2;
   localparam int unsigned   PW      = 2 * WIDTH;
   localparam int unsigned   RW      = WIDTH + 2;
   localparam km_prod_t      MU_FULL = km_barrett_mu(WIDTH, Q);
   localparam logic [PW-1:0] MU      = MU_FULL[PW-1:0];
   localparam logic [RW-1:0] QR      = RW'(Q);

   logic             advance;
   logic             s1_valid, s2_valid, s3_valid;
   logic             s1_err, s2_err, s3_err;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [WIDTH-1:0] s2_z0, s2_z2;
   logic [WIDTH+1:0] s2_z1;
   logic [PW-1:0]    s3_prod;

   logic [WIDTH-1:0] a_in, b_in;
   logic             err_in;
   logic [WIDTH-1:0] z0, z2;
   logic [WIDTH+1:0] z1, mid;
   logic [PW-1:0]    prod;
   logic [2*PW-1:0]  barrett;
   logic [PW-1:0]    qhat;
   logic [RW-1:0]    r0, r1, r2;
   logic [WIDTH-1:0] p_next;
   logic             unused_bits;

   // One global stall: a held output freezes every stage, bubbles included.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

`ifdef KM_MODMUL_RANGE_CHECK_EN
   localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

   always_comb begin
      a_in   = (a >= QW) ? a - QW : a;
      b_in   = (b >= QW) ? b - QW : b;
      err_in = (a >= QW) || (b >= QW);
   end
`else
   assign a_in   = a;
   assign b_in   = b;
   assign err_in = 1'b0;
`endif

   km_kara_mul #(.WIDTH(WIDTH)) u_kara (
      .a  (s1_a),
      .b  (s1_b),
      .z0 (z0),
      .z1 (z1),
      .z2 (z2)
   );

   // Barrett remainder is below 2Q, so its low RW bits are exact and the
   // multiply by Q only needs to be that wide.
   always_comb begin
      mid     = s2_z1 - {2'b00, s2_z2} - {2'b00, s2_z0};
      prod    = {s2_z2, s2_z0} + ({{(WIDTH-2){1'b0}}, mid} << H);
      barrett = {{PW{1'b0}}, s3_prod} * {{PW{1'b0}}, MU};
      qhat    = barrett[2*PW-1:PW];
      r0      = s3_prod[RW-1:0] - qhat[RW-1:0] * QR;
      r1      = (r0 >= QR) ? r0 - QR : r0;
      r2      = (r1 >= QR) ? r1 - QR : r1;
      p_next  = r2[WIDTH-1:0];
   end

   assign unused_bits = ^{barrett[PW-1:0], qhat[PW-1:RW], r2[RW-1:WIDTH]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         out_valid <= 1'b0;
         p         <= '0;
         range_err <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid && in_ready;
         s1_a      <= a_in;
         s1_b      <= b_in;
         s1_err    <= err_in;
         s2_valid  <= s1_valid;
         s2_z0     <= z0;
         s2_z1     <= z1;
         s2_z2     <= z2;
         s2_err    <= s1_err;
         s3_valid  <= s2_valid;
         s3_prod   <= prod;
         s3_err    <= s2_err;
         out_valid <= s3_valid;
         p         <= p_next;
         range_err <= s3_err;
      end
   end

endmodule

// File: tb/tb_km_modmul_pipe.sv
// Bench for km_modmul_pipe: random streams on three configurations, scored against (a*b) % Q.
module tb_km_modmul_pipe;

   localparam int unsigned W  = 14;
   localparam int unsigned QM = 16381;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, out_valid, out_ready, range_err;
   logic [W-1:0] a, b, p;

   km_modmul_pipe #(.WIDTH(W), .Q(QM)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .range_err(range_err)
   );

   logic       one = 1'b1;
   logic       rst8, v8, rdy8, ov8, err8;
   logic [7:0] a8, b8, p8;
   logic        rst16, v16, rdy16, ov16, err16;
   logic [15:0] a16, b16, p16;

   km_modmul_pipe #(.WIDTH(8), .Q(251)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(one), .p(p8), .range_err(err8)
   );

   km_modmul_pipe #(.WIDTH(16), .Q(65521)) dut16 (
      .clk(clk), .rst(rst16), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
      .out_valid(ov16), .out_ready(one), .p(p16), .range_err(err16)
   );

   typedef struct {
      logic [31:0] p;
      logic        err;
      int          cyc;
      int          stl;
   } exp_t;

   exp_t q_main[$];
   exp_t q8[$];
   exp_t q16[$];

   int   n_chk = 0, n_pass = 0, cyc = 0, stalls = 0, n8 = 0, n16 = 0;
   logic prev_rst = 1'b1, end_req = 1'b0, done8 = 1'b0, done16 = 1'b0;

   function automatic logic [31:0] ref_mod(input longint x, input longint y, input longint m);
      return 32'((x * y) % m);
   endfunction

   function automatic logic [W-1:0] rnd(input int unsigned lo, input int unsigned hi);
      return W'($urandom_range(hi, lo));
   endfunction

   task automatic chk(input string name, input bit ok, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
   endtask

   // Monitor: all scoring happens here, at the negedge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      logic ee;
      if (rst) begin
         q_main.delete();
      end else begin
         if (prev_rst) begin
            chk("reset_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
            chk("reset_p", p == '0, longint'(p), 0);
            chk("reset_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
            chk("reset_range_err", range_err == 1'b0, longint'(range_err), 0);
         end
         chk("in_ready", in_ready == (!out_valid || out_ready), longint'(in_ready),
             longint'(!out_valid || out_ready));
         if (out_valid && !out_ready) begin
            if (q_main.size() == 0) chk("stall_spurious", 1'b0, longint'(p), -1);
            else chk("stall_p", 32'(p) == q_main[0].p, longint'(p), longint'(q_main[0].p));
         end
         if (out_valid && out_ready) begin
            if (q_main.size() == 0) begin
               chk("spurious_out", 1'b0, longint'(p), -1);
            end else begin
               e = q_main.pop_front();
               chk("p", 32'(p) == e.p, longint'(p), longint'(e.p));
               chk("range_err", range_err == e.err, longint'(range_err), longint'(e.err));
               chk("latency", (cyc - e.cyc) == (4 + stalls - e.stl), longint'(cyc - e.cyc),
                   longint'(4 + stalls - e.stl));
            end
         end
         if (in_valid && in_ready) begin
`ifdef KM_MODMUL_RANGE_CHECK_EN
            ee = (32'(a) >= QM) || (32'(b) >= QM);
`else
            ee = 1'b0;
`endif
            q_main.push_back('{p: ref_mod(longint'(a), longint'(b), longint'(QM)), err: ee,
                               cyc: cyc, stl: stalls});
         end
         if (out_valid && !out_ready) stalls++;
      end
      prev_rst = rst;

      if (rst8) begin
         q8.delete();
      end else begin
         if (ov8) begin
            n8++;
            if (q8.size() == 0) begin
               chk("w8_spurious", 1'b0, longint'(p8), -1);
            end else begin
               e = q8.pop_front();
               chk("w8_p", 32'(p8) == e.p, longint'(p8), longint'(e.p));
               chk("w8_latency", (cyc - e.cyc) == 4, longint'(cyc - e.cyc), 4);
            end
         end
         if (v8 && rdy8)
            q8.push_back('{p: ref_mod(longint'(a8), longint'(b8), 251), err: 1'b0, cyc: cyc,
                           stl: 0});
      end

      if (rst16) begin
         q16.delete();
      end else begin
         if (ov16) begin
            n16++;
            if (q16.size() == 0) begin
               chk("w16_spurious", 1'b0, longint'(p16), -1);
            end else begin
               e = q16.pop_front();
               chk("w16_p", 32'(p16) == e.p, longint'(p16), longint'(e.p));
               chk("w16_range_err", err16 == 1'b0, longint'(err16), 0);
            end
         end
         if (v16 && rdy16)
            q16.push_back('{p: ref_mod(longint'(a16), longint'(b16), 65521), err: 1'b0,
                            cyc: cyc, stl: 0});
      end

      if (end_req) begin
         chk("drain_main", q_main.size() == 0, longint'(q_main.size()), 0);
         chk("drain_w8", q8.size() == 0, longint'(q8.size()), 0);
         chk("drain_w16", q16.size() == 0, longint'(q16.size()), 0);
         chk("w8_count", n8 == 251 * 251, longint'(n8), 251 * 251);
         chk("w16_count", n16 == 10000, longint'(n16), 10000);
      end
      cyc++;
   end

   task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      a         = x;
      b         = y;
      out_ready = r;
   endtask

   initial begin
      logic [W-1:0] ca [5];
      logic [W-1:0] cb [5];
      ca = '{14'd1, 14'd16380, 14'd8191, 14'd0, 14'd16380};
      cb = '{14'd1, 14'd16380, 14'd2, 14'd12345, 14'd1};

      rst = 1'b1; in_valid = 1'b1; a = 14'd5; b = 14'd7; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      repeat (4) step(1'b0, '0, '0, 1'b1);

      for (int i = 0; i < 5; i++) begin
         step(1'b1, ca[i], cb[i], 1'b1);
         repeat (6) step(1'b0, '0, '0, 1'b1);
      end

      // Three beats in flight when reset hits: none may surface afterwards.
      repeat (3) step(1'b1, rnd(1, QM - 1), rnd(1, QM - 1), 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) step(1'b0, '0, '0, 1'b1);

      for (int i = 0; i < 30000; i++) step(1'b1, rnd(1, QM - 1), rnd(1, QM - 1), 1'b1);

      for (int i = 0; i < 60; i++)
         step(1'b1, rnd(0, QM - 1), rnd(0, QM - 1), !(i >= 20 && i < 25));

      for (int i = 0; i < 3000; i++)
         step($urandom_range(3, 0) != 0, rnd(0, QM - 1), rnd(0, QM - 1),
              $urandom_range(3, 0) != 0);

`ifdef KM_MODMUL_RANGE_CHECK_EN
      step(1'b1, 14'd16381, 14'd5, 1'b1);
      step(1'b1, 14'd16383, 14'd3, 1'b1);
      step(1'b1, 14'd3, 14'd3, 1'b1);
      for (int i = 0; i < 200; i++) step(1'b1, rnd(0, 16383), rnd(0, 16383), 1'b1);
`endif

      for (int i = 0; i < 50 && q_main.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 80000 && !(done8 && done16); i++) @(posedge clk);

      end_req = 1'b1;
      @(negedge clk);
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      rst8 = 1'b1; v8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst8 = 1'b0;
      for (int i = 0; i < 251; i++) begin
         for (int j = 0; j < 251; j++) begin
            @(posedge clk);
            #1;
            v8 = 1'b1; a8 = 8'(i); b8 = 8'(j);
         end
      end
      @(posedge clk);
      #1;
      v8 = 1'b0;
      repeat (8) @(posedge clk);
      done8 = 1'b1;
   end

   initial begin
      rst16 = 1'b1; v16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst16 = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         @(posedge clk);
         #1;
         v16 = 1'b1; a16 = 16'($urandom_range(65520, 0)); b16 = 16'($urandom_range(65520, 0));
      end
      @(posedge clk);
      #1;
      v16 = 1'b0;
      repeat (8) @(posedge clk);
      done16 = 1'b1;
   end

endmodule

// File: doc/km_modmul_pipe.md
# km_modmul_pipe

Pipelined, parametrised modular multiplier computing p = (a·b) mod Q for WIDTH-bit operands. It is the clocked, streaming successor of the combinational Karatsuba modular multiplier. It uses a one-level Karatsuba multiply followed by Barrett reduction, with a valid/ready handshake on both sides. It sits between operand producers (NTT/butterfly datapath) and result consumers, and accepts one operation per cycle when not stalled.

## Interface
- WIDTH, 14: operand and result width in bits; even, 4..32.
- Q, 16381: modulus; 2 ≤ Q < 2^WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A; must be < Q unless KM_MODMUL_RANGE_CHECK_EN is defined.
- b  in  WIDTH  operand B; same rule as a.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- p  out  WIDTH  result (a·b) mod Q, range 0..Q-1.
- range_err  out  1  beat carried an operand ≥ Q; constant 0 without the macro.

## Operation
- A beat is accepted when in_valid && in_ready. It is delivered when out_valid && out_ready.
- Pipeline has 4 register stages, each with a valid bit:
  - S1: operand register, with optional pre-reduction.
  - S2: Karatsuba partials. Split h = WIDTH/2: z2 = aH·bH, z0 = aL·bL, z1 = (aH+aL)(bH+bL) on (h+1)-bit sums.
  - S3: product P = z2·2^(2h) + (z1−z2−z0)·2^h + z0, 2·WIDTH bits.
  - S4: Barrett. MU = floor(2^(2·WIDTH)/Q) is an elaboration-time constant. qhat = (P·MU) >> 2·WIDTH and r = P − qhat·Q, held in WIDTH+2 bits. Then up to two conditional subtracts of Q into the output register.
- Result r is exact: 0 ≤ r < Q for all a, b < Q.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
- When advance is low, all stages hold, including bubbles. Bubbles are not squeezed out.
- Each stage's valid bit loads the previous stage's valid when advance is high. S1 valid loads in_valid && in_ready.
- p and range_err are held stable while out_valid && !out_ready.
- Reset clears all valid bits. Data registers are don't-care after reset.
- Reset mid-operation discards every in-flight beat. No result is produced for beats accepted before the reset.

## Timing
- Reset values: out_valid = 0, in_ready = 1 (in the cycle after rst deasserts, with out_valid = 0), p = 0, range_err = 0.
- Latency is 4 cycles. A beat accepted in cycle k shows out_valid = 1 in cycle k+4, provided no stall occurs.
- Throughput is 1 beat per cycle with out_ready held high.
- Stall of n cycles delays every in-flight beat by exactly n cycles. No beat is lost or duplicated.
- in_ready depends combinationally only on out_valid and out_ready. There is no path from in_valid to in_ready.
- Simultaneous accept and deliver in the same cycle is legal and is the steady state.

## Configuration
- KM_MODMUL_RANGE_CHECK_EN defined:
  - S1 compares a and b with Q and subtracts Q once from any operand ≥ Q. Single subtract is sufficient because 2Q > 2^WIDTH−1 is required when the macro is used.
  - range_err is carried down the pipeline and presented with the corresponding p.
- Macro undefined:
  - No compare logic.
  - Operands ≥ Q give an unspecified p.
  - range_err is tied to 0.

## Structure
- Shared package km_pkg holds:
  - KM_WIDTH_DEF = 14 and KM_Q_DEF = 16381.
  - Function km_barrett_mu(width, q) returning floor(2^(2·width)/q).
  - Typedef for the 2·WIDTH product.
- One sub-module is natural: km_kara_mul. It is a combinational, one-level Karatsuba multiplier parametrised by WIDTH that returns z0, z1, z2, and is instantiated in S2.
- Pipeline control (valid bits, advance) lives in the top module.

## Test plan
- Reset: assert rst 3 cycles with in_valid = 1 → out_valid = 0, p = 0, in_ready = 1 after release. Pulse rst with 3 beats in flight → none of those beats emerge.
- Corners (Q = 16381): 1·1 → 1; 16380·16380 → 1; 8191·2 → 1; 0·12345 → 0; 16380·1 → 16380. Each appears exactly 4 cycles after accept.
- Stream 30000 random beats with a, b in 1..16380 and out_ready = 1 → every p equals a·b mod 16381, in order. Zero mismatches, one result per cycle.
- Backpressure: stream continuously, drop out_ready for 5 cycles → in_ready = 0 for those 5 cycles, p held stable, and the sequence resumes with no loss or duplication.
- Parameter sweep: WIDTH = 8 with Q = 251, and WIDTH = 16 with Q = 65521 → exhaustive (8-bit) and 10000 random (16-bit) checks all correct.
- With KM_MODMUL_RANGE_CHECK_EN: a = 16381, b = 5 → p = 0, range_err = 1. a = 16383, b = 3 → p = 6, range_err = 1. a = 3, b = 3 → p = 9, range_err = 0.
